keypad_matrix_emu: RTL and testbench

- Synthesizable 4x4 matrix-keypad emulator: the responder end of the row-strobe/column-sense keypad scan interface.
- Watches the row strobes driven by the keypad scanner and drives the column sense lines as if one physical key were pressed.
- Emulates contact bounce on both the press and release edges.
- Used on board builds without a physical keypad and in loop-back benches: the scanner plus debounce filter sit on the other side of row/col.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/bounce_lfsr.sv | 27 ++
 rtl/keypad_matrix_emu.sv | 130 +++++++++++++
 tb/tb_keypad_matrix_emu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and its emulated responder:
// matrix geometry, line polarity, FSM states and the contact-bounce LFSR.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Rows and columns are both active-low on the wire.
  localparam logic ROW_ACTIVE = 1'b0;
  localparam logic COL_ACTIVE = 1'b0;

  // x^8+x^6+x^5+x^4+1 as a mask over the shift-left register bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT
  } key_state_e;

  function automatic logic lfsr_contact(input logic [7:0] q);
    return q[0];
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 8-bit Fibonacci LFSR that supplies pseudo-random contact chatter.
// Reseeds on reset so the bounce pattern is repeatable from power-up.
module bounce_lfsr
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       RSTn,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] q_reg;
  logic       fb_next;

  assign fb_next = ^(q_reg & LFSR_TAPS);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      q_reg <= LFSR_SEED;
    end else if (en) begin
      q_reg <= {q_reg[6:0], fb_next};
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/keypad_matrix_emu.sv
// 4x4 matrix-keypad emulator: answers the scanner's row strobes on the column
// sense lines as if one key were pressed, with chatter on press and release.
module keypad_matrix_emu
  import keypad_pkg::*;
#(
  parameter int BOUNCE_LEN = 16,
  parameter int HOLD_W     = 24
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              start,
  input  logic [3:0]        code,
  input  logic [HOLD_W-1:0] hold,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic              busy,
  output logic              done,
  output logic              pressed
);

  localparam int BL_W  = (BOUNCE_LEN > 0) ? $clog2(BOUNCE_LEN + 1) : 1;
  localparam int CNT_W = (HOLD_W > BL_W) ? HOLD_W : BL_W;
  localparam logic [CNT_W-1:0] BOUNCE_CNT = CNT_W'(BOUNCE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  key_state_e        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [3:0]        code_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [HOLD_W-1:0] hold_eff;
  logic [7:0]        lfsr_q;
  logic              lfsr_en;
  logic              contact;
  logic              row_hit;

  assign hold_eff = (hold == '0) ? HOLD_W'(1) : hold;
  assign lfsr_en  = (state_reg == BOUNCE_IN) || (state_reg == BOUNCE_OUT);

  bounce_lfsr u_lfsr (
    .clk  (clk),
    .RSTn (RSTn),
    .en   (lfsr_en),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hold_reg  <= '0;
      code_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            code_reg <= code;
            hold_reg <= hold_eff;
            busy_reg <= 1'b1;
            if (BOUNCE_LEN == 0) begin
              state_reg <= HOLD;
              cnt_reg   <= CNT_W'(hold_eff);
            end else begin
              state_reg <= BOUNCE_IN;
              cnt_reg   <= BOUNCE_CNT;
            end
          end
        end
        BOUNCE_IN: begin
          if (cnt_reg == CNT_ONE) begin
            state_reg <= HOLD;
            cnt_reg   <= CNT_W'(hold_reg);
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt_reg != CNT_ONE) begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end else if (BOUNCE_LEN == 0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= BOUNCE_OUT;
            cnt_reg   <= BOUNCE_CNT;
          end
        end
        BOUNCE_OUT: begin
          if (cnt_reg == CNT_ONE) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Contact is decoded from flops only, so reset clears it without waiting for a clock.
  always_comb begin
    contact = 1'b0;
    case (state_reg)
      BOUNCE_IN, BOUNCE_OUT: contact = lfsr_contact(lfsr_q);
      HOLD:                  contact = 1'b1;
      default:               contact = 1'b0;
    endcase
  end

  assign row_hit = (row[code_reg[3:2]] == ROW_ACTIVE);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col[gi] = (contact && row_hit && (code_reg[1:0] == 2'(gi))) ? COL_ACTIVE : ~COL_ACTIVE;
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign pressed = contact;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Directed bench for keypad_matrix_emu: one instance without bounce, one with
// the default 16-cycle chatter, both on the same clock, reset and row lines.
module tb_keypad_matrix_emu;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        start0 = 1'b0;
  logic        start16 = 1'b0;
  logic [3:0]  code = 4'd0;
  logic [23:0] hold = 24'd0;
  logic [3:0]  row = 4'b1111;
  logic [3:0]  col0, col16;
  logic        busy0, done0, pressed0;
  logic        busy16, done16, pressed16;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  lfsr_m;
  logic [3:0]  row_pat [4];

  keypad_matrix_emu #(.BOUNCE_LEN(0), .HOLD_W(24)) u_dut0 (
    .clk(clk), .RSTn(RSTn), .start(start0), .code(code), .hold(hold), .row(row),
    .col(col0), .busy(busy0), .done(done0), .pressed(pressed0)
  );

  keypad_matrix_emu #(.BOUNCE_LEN(16), .HOLD_W(24)) u_dut16 (
    .clk(clk), .RSTn(RSTn), .start(start16), .code(code), .hold(hold), .row(row),
    .col(col16), .busy(busy16), .done(done16), .pressed(pressed16)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lfsr_adv();
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  endtask

  // One bounce phase on the 16-cycle instance with row 3 strobed (key 15).
  task automatic bounce_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_pressed"}, pressed16, lfsr_m[0]);
      check({tag, "_col"}, col16, {~lfsr_m[0], 3'b111});
      check({tag, "_busy"}, busy16, 1'b1);
      lfsr_adv();
      step();
    end
  endtask

  initial begin
    row_pat[0] = 4'b1110;
    row_pat[1] = 4'b1101;
    row_pat[2] = 4'b1011;
    row_pat[3] = 4'b0111;

    // Reset state, both during and after reset, with every row strobed.
    repeat (2) step();
    for (int r = 0; r < 4; r++) begin
      row = row_pat[r];
      #1;
      check("rst_col0", col0, 4'b1111);
      check("rst_col16", col16, 4'b1111);
    end
    check("rst_busy", {busy0, busy16}, 2'b00);
    check("rst_done", {done0, done16}, 2'b00);
    check("rst_pressed", {pressed0, pressed16}, 2'b00);
    step();
    RSTn = 1'b1;
    step();
    for (int r = 0; r < 4; r++) begin
      row = row_pat[r];
      #1;
      check("idle_col0", col0, 4'b1111);
      check("idle_col16", col16, 4'b1111);
    end
    check("idle_flags", {busy0, done0, pressed0, busy16, done16, pressed16}, 6'b0);

    // No bounce: key 6 (row 1, col 2), hold 10, with an ignored start mid-press.
    step();
    code = 4'd6;
    hold = 24'd10;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 6) start0 = 1'b0;
      for (int r = 0; r < 4; r++) begin
        row = row_pat[r];
        #1;
        check("nb_col", col0, (row_pat[r] == 4'b1101) ? 4'b1011 : 4'b1111);
      end
      check("nb_busy", busy0, 1'b1);
      check("nb_pressed", pressed0, 1'b1);
      check("nb_done", done0, 1'b0);
      if (i == 5) begin
        start0 = 1'b1;
        code = 4'd0;
        hold = 24'd3;
      end
      step();
    end
    row = 4'b1101;
    #1;
    check("nb_done_pulse", done0, 1'b1);
    check("nb_done_busy", busy0, 1'b0);
    check("nb_done_pressed", pressed0, 1'b0);
    check("nb_done_col", col0, 4'b1111);

    // Back-to-back press from the done cycle, with hold 0 acting as 1.
    start0 = 1'b1;
    code = 4'd6;
    hold = 24'd0;
    step();
    start0 = 1'b0;
    check("b2b_busy", busy0, 1'b1);
    check("b2b_pressed", pressed0, 1'b1);
    check("b2b_col", col0, 4'b1011);
    check("b2b_done", done0, 1'b0);
    step();
    check("h0_done", done0, 1'b1);
    check("h0_busy", busy0, 1'b0);
    step();
    check("h0_done_once", done0, 1'b0);
    check("h0_idle_busy", busy0, 1'b0);

    // With bounce: key 15, hold 100, row 3 held low.
    row = 4'b0111;
    code = 4'd15;
    hold = 24'd100;
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    lfsr_m = 8'hA5;
    bounce_check("bin", 16);
    for (int i = 0; i < 100; i++) begin
      check("hold_pressed", pressed16, 1'b1);
      check("hold_col", col16, 4'b0111);
      check("hold_busy", busy16, 1'b1);
      if (i == 50) begin
        row = 4'b1011;
        #1;
        check("hold_other_row", col16, 4'b1111);
        row = 4'b0111;
      end
      step();
    end
    bounce_check("bout", 16);
    check("b_done", done16, 1'b1);
    check("b_done_busy", busy16, 1'b0);
    check("b_done_col", col16, 4'b1111);
    check("b_done_pressed", pressed16, 1'b0);
    step();
    check("b_done_once", done16, 1'b0);

    // Reset in the middle of HOLD, then a fresh press restarts from the seed.
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    repeat (26) step();
    check("mid_hold_col", col16, 4'b0111);
    RSTn = 1'b0;
    #1;
    check("arst_col", col16, 4'b1111);
    check("arst_busy", busy16, 1'b0);
    check("arst_pressed", pressed16, 1'b0);
    step();
    step();
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_no_done", done16, 1'b0);
      check("arst_idle", busy16, 1'b0);
    end
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    lfsr_m = 8'hA5;
    bounce_check("rbin", 16);
    check("rhold_pressed", pressed16, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
